swiglu_gate_mul: RTL and testbench

- Downstream stage of the vector-engine SiLU activation.
- Takes the per-lane SiLU output (gate vector) and pairs it with the matching up-projection vector.
- Multiplies each pair lane-wise, then rescales by a runtime shift with round-half-up and saturation, producing the SwiGLU result in the same fixed-point format.
- The SiLU stage has no backpressure, so gate vectors are buffered in an internal FIFO until their up vector arrives.

---
 rtl/swiglu_gate_mul_if.sv | 24 ++
 rtl/swiglu_gate_mul.sv | 151 +++++++++++++++
 tb/tb_swiglu_gate_mul.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/swiglu_gate_mul_if.sv
// Vector-stream bundle between the SiLU stage, the up-projection source and the
// SwiGLU gate multiplier: gate/up input lanes, up handshake and result lanes.
interface swiglu_gate_mul_if #(
  parameter int BUS_NUM          = 8,
  parameter int FIXED_DATA_WIDTH = 8
);
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] in_gate_data;
  logic [BUS_NUM-1:0]                  in_gate_data_vld;
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] in_up_data;
  logic [BUS_NUM-1:0]                  in_up_data_vld;
  logic                                in_up_rdy;
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] out_fixed_data;
  logic [BUS_NUM-1:0]                  out_fixed_data_vld;

  modport master (
    output in_gate_data, in_gate_data_vld, in_up_data, in_up_data_vld,
    input  in_up_rdy, out_fixed_data, out_fixed_data_vld
  );

  modport slave (
    input  in_gate_data, in_gate_data_vld, in_up_data, in_up_data_vld,
    output in_up_rdy, out_fixed_data, out_fixed_data_vld
  );
endinterface

// File: rtl/swiglu_gate_mul.sv
// SwiGLU gate multiplier: buffers SiLU gate vectors in a small FIFO, pairs each with
// an up-projection vector, multiplies lane-wise, then rounds, shifts and saturates.
module swiglu_gate_mul #(
  parameter int BUS_NUM          = 8,
  parameter int SCALA_POS_WIDTH  = 5,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  swiglu_gate_mul_if.slave              bus,
  input  logic [SCALA_POS_WIDTH-1:0]    scale_shift,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow_err
);

  localparam int W  = FIXED_DATA_WIDTH;
  localparam int PW = 2 * W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [PW:0] SAT_MAX = (PW+1)'(2**(W-1) - 1);
  localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

  typedef logic [BUS_NUM*W-1:0] vec_t;
  typedef logic [BUS_NUM-1:0]   mask_t;

  function automatic logic signed [PW-1:0] mul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = PW'(a);
    be = PW'(b);
    return ae * be;
  endfunction

  // One guard bit above the product keeps the rounding add from wrapping.
  function automatic logic signed [W-1:0] scale_sat(input logic signed [PW-1:0]      p,
                                                    input logic [SCALA_POS_WIDTH-1:0] s);
    logic signed [PW:0] ext;
    logic signed [PW:0] rnd;
    logic signed [PW:0] r;
    ext = {p[PW-1], p};
    rnd = '0;
    if (s == '0) begin
      r = ext;
    end else if (int'(s) >= PW) begin
      r = '0;
    end else begin
      rnd = ext + ((PW+1)'(1) << (s - 1'b1));
      r   = rnd >>> s;
    end
    if (r > SAT_MAX)      return W'(SAT_MAX);
    else if (r < SAT_MIN) return W'(SAT_MIN);
    else                  return W'(r);
  endfunction

  vec_t  [FIFO_DEPTH-1:0] data_mem_q, data_mem_d;
  mask_t [FIFO_DEPTH-1:0] mask_mem_q, mask_mem_d;
  logic  [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic  [CW-1:0]         cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic  [BUS_NUM-1:0][PW-1:0] prod_q, prod_d;
  mask_t                  lane_vld_q, lane_vld_d;
  vec_t                   out_data_q, out_data_d;
  mask_t                  out_vld_q, out_vld_d;

  logic gate_present, up_present, full, up_rdy, pop, push;

  assign gate_present = |bus.in_gate_data_vld;
  assign up_present   = |bus.in_up_data_vld;
  assign full         = (cnt_q == CW'(FIFO_DEPTH));
  assign up_rdy       = (cnt_q != '0);
  assign pop          = up_present & up_rdy;
  assign push         = gate_present & (~full | pop);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    data_mem_d = data_mem_q;
    mask_mem_d = mask_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q | (gate_present & full & ~pop);
    if (push) begin
      data_mem_d[wr_ptr_q] = bus.in_gate_data;
      mask_mem_d[wr_ptr_q] = bus.in_gate_data_vld;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Stage 1: the head entry is read before any same-cycle write lands.
  always_comb begin
    prod_d     = '0;
    lane_vld_d = '0;
    if (pop) begin
      for (int i = 0; i < BUS_NUM; i++) begin
        prod_d[i] = mul(data_mem_q[rd_ptr_q][i*W +: W], bus.in_up_data[i*W +: W]);
      end
      lane_vld_d = mask_mem_q[rd_ptr_q] & bus.in_up_data_vld;
    end
  end

  always_comb begin
    out_data_d = '0;
    out_vld_d  = lane_vld_q;
    for (int i = 0; i < BUS_NUM; i++) begin
      if (lane_vld_q[i]) out_data_d[i*W +: W] = scale_sat(prod_q[i], scale_shift);
    end
  end

  // NOTE: the FIFO storage is reset too, so a popped-but-never-written slot can't leak X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_mem_q <= '0;
      mask_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      prod_q     <= '0;
      lane_vld_q <= '0;
      out_data_q <= '0;
      out_vld_q  <= '0;
    end else begin
      // NOTE: non-blocking only here, so every flop samples the pre-edge values.
      data_mem_q <= data_mem_d;
      mask_mem_q <= mask_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      prod_q     <= prod_d;
      lane_vld_q <= lane_vld_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign bus.in_up_rdy          = up_rdy;
  assign bus.out_fixed_data     = out_data_q;
  assign bus.out_fixed_data_vld = out_vld_q;
  assign fifo_cnt               = cnt_q;
  assign overflow_err           = ovf_q;

endmodule

// File: tb/tb_swiglu_gate_mul.sv
// Directed bench for swiglu_gate_mul: rounding, saturation, masking, ordering,
// overflow, up-before-gate handshake and asynchronous reset, all with fixed vectors.
module tb_swiglu_gate_mul;

  logic       clk;
  logic       rst_n;
  logic [4:0] scale_shift;
  logic [2:0] fifo_cnt;
  logic       overflow_err;
  int         checks   = 0;
  int         failures = 0;

  swiglu_gate_mul_if #(.BUS_NUM(8), .FIXED_DATA_WIDTH(8)) bus ();

  swiglu_gate_mul #(
    .BUS_NUM(8), .SCALA_POS_WIDTH(5), .FIXED_DATA_WIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .scale_shift  (scale_shift),
    .fifo_cnt     (fifo_cnt),
    .overflow_err (overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] g, input logic [7:0] gv,
                       input logic [63:0] u, input logic [7:0] uv);
    bus.in_gate_data     = g;
    bus.in_gate_data_vld = gv;
    bus.in_up_data       = u;
    bus.in_up_data_vld   = uv;
  endtask

  task automatic check_out(input string tag, input logic [63:0] d, input logic [7:0] v);
    check({tag, "_data"}, bus.out_fixed_data, d);
    check({tag, "_vld"}, 64'(bus.out_fixed_data_vld), 64'(v));
  endtask

  initial begin
    rst_n       = 1'b0;
    scale_shift = 5'd4;
    drive('0, '0, '0, '0);
    cyc();
    cyc();
    check_out("reset", 64'h0, 8'h00);
    check("reset_cnt", 64'(fifo_cnt), 64'd0);
    check("reset_ovf", 64'(overflow_err), 64'd0);
    check("reset_rdy", 64'(bus.in_up_rdy), 64'd0);
    rst_n = 1'b1;
    cyc();

    // 20*10 = 200 -> (200+8)>>>4 = 13
    drive(64'h14, 8'h01, '0, '0);
    cyc();
    check("basic_cnt", 64'(fifo_cnt), 64'd1);
    check("basic_rdy", 64'(bus.in_up_rdy), 64'd1);
    drive('0, '0, 64'h0A, 8'h01);
    cyc();
    check("basic_lat1_vld", 64'(bus.out_fixed_data_vld), 64'h0);
    check("basic_pop_cnt", 64'(fifo_cnt), 64'd0);
    drive('0, '0, '0, '0);
    cyc();
    check_out("basic_pos", 64'h0D, 8'h01);

    // -20*10 = -200 -> (-192)>>>4 = -12
    drive(64'hEC, 8'h01, '0, '0);
    cyc();
    drive('0, '0, 64'h0A, 8'h01);
    cyc();
    drive('0, '0, '0, '0);
    cyc();
    check_out("basic_neg", 64'hF4, 8'h01);

    // 64*32 = 2048 -> 2056>>>4 = 128 -> saturates to 127
    drive(64'h40, 8'h01, '0, '0);
    cyc();
    drive('0, '0, 64'h20, 8'h01);
    cyc();
    drive('0, '0, '0, '0);
    cyc();
    check_out("sat_s4", 64'h7F, 8'h01);

    // s=0: -128*-128 -> 127, -128*127 -> -128, 3*-5 = -15
    scale_shift = 5'd0;
    drive(64'h03_80_80, 8'h07, '0, '0);
    cyc();
    drive('0, '0, 64'hFB_7F_80, 8'h07);
    cyc();
    drive('0, '0, '0, '0);
    cyc();
    check_out("sat_s0", 64'hF1_80_7F, 8'h07);

    // masks 0x0F & 0x3C = 0x0C; s=1: 2*16 = 32 -> 33>>>1 = 16
    scale_shift = 5'd1;
    drive(64'h0202_0202_0202_0202, 8'h0F, '0, '0);
    cyc();
    drive('0, '0, 64'h1010_1010_1010_1010, 8'h3C);
    cyc();
    drive('0, '0, '0, '0);
    cyc();
    check_out("mask", 64'h0000_0000_1010_0000, 8'h0C);

    // ordering: A=16, B=32, C=48 times up=16 at s=4 give 16, 32, 48
    scale_shift = 5'd4;
    drive(64'h10, 8'h01, '0, '0);
    cyc();
    drive(64'h20, 8'h01, '0, '0);
    cyc();
    drive(64'h30, 8'h01, '0, '0);
    cyc();
    drive('0, '0, '0, '0);
    check("order_cnt3", 64'(fifo_cnt), 64'd3);
    check("order_rdy1", 64'(bus.in_up_rdy), 64'd1);
    drive('0, '0, 64'h10, 8'h01);
    cyc();
    cyc();
    check_out("order_a", 64'h10, 8'h01);
    cyc();
    check_out("order_b", 64'h20, 8'h01);
    check("order_cnt0", 64'(fifo_cnt), 64'd0);
    check("order_rdy0", 64'(bus.in_up_rdy), 64'd0);
    drive('0, '0, '0, '0);
    cyc();
    check_out("order_c", 64'h30, 8'h01);
    cyc();
    check_out("idle", 64'h0, 8'h00);

    // full at 4, 5th gate with pop accepted, 6th gate without pop dropped
    for (int i = 1; i <= 4; i++) begin
      drive(64'(i * 16), 8'h01, '0, '0);
      cyc();
    end
    check("full_cnt", 64'(fifo_cnt), 64'd4);
    drive(64'h50, 8'h01, 64'h10, 8'h01);
    cyc();
    check("full_pushpop_cnt", 64'(fifo_cnt), 64'd4);
    check("full_pushpop_ovf", 64'(overflow_err), 64'd0);
    drive(64'h60, 8'h01, '0, '0);
    cyc();
    check("drop_cnt", 64'(fifo_cnt), 64'd4);
    check("drop_ovf", 64'(overflow_err), 64'd1);
    check_out("drain_d0", 64'h10, 8'h01);
    drive('0, '0, 64'h10, 8'h01);
    cyc();
    check_out("drain_gap", 64'h0, 8'h00);
    cyc();
    check_out("drain_d1", 64'h20, 8'h01);
    cyc();
    check_out("drain_d2", 64'h30, 8'h01);
    cyc();
    check_out("drain_d3", 64'h40, 8'h01);
    check("drain_cnt", 64'(fifo_cnt), 64'd0);
    drive('0, '0, '0, '0);
    cyc();
    check_out("drain_g5", 64'h50, 8'h01);
    cyc();
    check_out("drain_end", 64'h0, 8'h00);
    check("ovf_sticky", 64'(overflow_err), 64'd1);

    // up vector held while empty; 112*16 -> 1800>>>4 = 112
    drive('0, '0, 64'h10, 8'h01);
    cyc();
    cyc();
    cyc();
    check_out("upfirst_wait", 64'h0, 8'h00);
    check("upfirst_rdy0", 64'(bus.in_up_rdy), 64'd0);
    drive(64'h70, 8'h01, 64'h10, 8'h01);
    cyc();
    check("upfirst_rdy1", 64'(bus.in_up_rdy), 64'd1);
    check("upfirst_cnt1", 64'(fifo_cnt), 64'd1);
    drive('0, '0, 64'h10, 8'h01);
    cyc();
    check("upfirst_pop_cnt", 64'(fifo_cnt), 64'd0);
    drive('0, '0, '0, '0);
    cyc();
    check_out("upfirst_out", 64'h70, 8'h01);

    // asynchronous reset with data in flight
    drive(64'h10, 8'h01, '0, '0);
    cyc();
    drive(64'h20, 8'h01, '0, '0);
    cyc();
    drive('0, '0, 64'h10, 8'h01);
    cyc();
    cyc();
    check_out("prerst", 64'h10, 8'h01);
    drive('0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("midrst", 64'h0, 8'h00);
    check("midrst_cnt", 64'(fifo_cnt), 64'd0);
    check("midrst_ovf", 64'(overflow_err), 64'd0);
    check("midrst_rdy", 64'(bus.in_up_rdy), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check_out("postrst_1", 64'h0, 8'h00);
    cyc();
    check_out("postrst_2", 64'h0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
